kurm_alu_sequencer: RTL and testbench
=====================================

# kurm_alu_sequencer

Multi-cycle control sequencer that drives the KURM ALU: it accepts 16-bit instructions from fetch, decodes them, and issues `alu_op`/`alu_c_in` and register-file addresses. It captures the ALU's `lt`/`eq`/`gt`/`c_out` into architectural flags and resolves conditional branches from those flags. It sits between the fetch stage and the ALU/register-file datapath, on the initiator side of the ALU's opcode and flag interface.

## Interface
- `REG_AW`, 4, register address width. Only 4 is legal with the 16-bit KURM encoding.
- `BR_OFF_W`, 8, branch offset width. Equals `2*REG_AW`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  16  instruction word. Fields: opcode[15:12], rd[11:8], rs[7:4], rt[3:0]; branch offset = [7:0].
- `instr_valid`  in  1  fetch presents `instr`.
- `instr_ready`  out  1  sequencer can accept.
- `alu_lt`, `alu_eq`, `alu_gt`, `alu_c_out`  in  1 each  ALU status.
- `alu_op`  out  3  ALU opcode: 000 AND, 001 ORR, 010 ADD, 011 SUB, 111 SLT.
- `alu_c_in`  out  1  ALU carry in.
- `rf_ra`, `rf_rb`  out  `REG_AW`  read addresses (rs, rt).
- `rf_wa`  out  `REG_AW`  write address (rd).
- `rf_we`  out  1  register write strobe; the register file captures ALU `z` on this edge.
- `br_taken`  out  1  branch resolved taken.
- `br_offset`  out  `BR_OFF_W`  taken-branch offset.
- `flag_lt`, `flag_eq`, `flag_gt`, `flag_c`  out  1 each  architectural flags.
- `done`  out  1  instruction retired.
- `illegal`  out  1  undefined opcode retired.

## Operation
- Opcodes:
  - 0000 AND, 0001 ORR, 0010 ADD (c_in=0), 0011 SUB, 0100 ADC (ADD with c_in=`flag_c`), 0111 SLT.
  - 1000 CMP: SUB with no writeback.
  - 1001 BEQ, 1010 BLT, 1011 BGT.
  - 1111 NOP.
  - All other opcodes are illegal.
- FSM states and transitions:
  - IDLE -> DECODE on `instr_valid & instr_ready`.
  - DECODE -> EXEC for ALU ops and CMP.
  - DECODE -> BRANCH for branches.
  - DECODE -> WB for NOP and illegal.
  - EXEC -> WB.
  - WB -> IDLE.
  - BRANCH -> IDLE.
- `instr_ready` = (state == IDLE). The instruction is latched on acceptance; `instr` is ignored at all other times.
- DECODE: `rf_ra`/`rf_rb`/`rf_wa` driven from the latched fields and held until the return to IDLE.
- EXEC: `alu_op`/`alu_c_in` driven and held through WB.
- Flag capture at the end of EXEC:
  - `flag_c` <= `alu_c_out` for ADD, ADC, SUB, CMP.
  - `flag_lt`/`flag_eq`/`flag_gt` <= ALU status for SUB, CMP, SLT.
  - AND/ORR leave all flags unchanged.
- WB: `done`=1.
  - `rf_we`=1 for AND, ORR, ADD, ADC, SUB, SLT.
  - `rf_we`=0 for CMP, NOP, illegal.
  - `illegal`=1 only for undefined opcodes.
- BRANCH: `done`=1 and `br_offset`=instr[7:0].
  - `br_taken` = `flag_eq` (BEQ), `flag_lt` (BLT), `flag_gt` (BGT).
  - Branches never modify flags.
- ADC chains: `alu_c_in` uses `flag_c` as it stood before this instruction's EXEC.

## Timing
- Acceptance at edge N. DECODE occupies cycle N+1.
- ALU/CMP: EXEC in N+2, WB in N+3 (`done`, `rf_we` high), `instr_ready` high in N+4. Four cycles per instruction.
- Branch: BRANCH in N+2 (`done`, `br_taken` valid), ready in N+3.
- NOP/illegal: WB in N+2, ready in N+3.
- `done`, `rf_we`, `br_taken` and `illegal` are single-cycle pulses; they are 0 outside their state.
- Reset values: state IDLE, so `instr_ready`=1. All other outputs 0, including `alu_op`=000, all flags, and `br_offset`.
- Reset mid-operation: the instruction is abandoned, no `rf_we`/`done` pulse occurs, and flags clear.
- Reset has priority over acceptance in the same cycle.
- `instr_valid` held high continuously: the next instruction is accepted in the first IDLE cycle, with no bubble beyond IDLE.

## Structure
- Shared package `kurm_pkg`:
  - opcode localparams (`OP_AND` … `OP_NOP`);
  - ALUOp encodings (`ALU_AND`=000, `ALU_ORR`=001, `ALU_ADD`=010, `ALU_SUB`=011, `ALU_SLT`=111);
  - FSM state encoding.
- One sub-module, `kurm_decode`: combinational map from opcode to {alu_op, use_carry, writes_rd, sets_c, sets_cmp, is_branch, is_illegal}.
- The FSM and flag registers live in the top module.

## Test plan
- Reset, then ADD r1,r2,r3 with the ALU modelled (r2=0x0001, r3=0x0002) -> `rf_we` pulse in N+3 with `rf_wa`=1, `alu_op`=010, `alu_c_in`=0, `flag_c`=0.
- ADD with 0xAAAA+0xAAAA, then ADC -> `flag_c`=1 after ADD. ADC shows `alu_c_in`=1 and `alu_op`=010 in its EXEC.
- CMP 0x0002 vs 0x0004, then BLT offset 0x10 -> CMP produces no `rf_we`, `flag_lt`=1. BLT `br_taken`=1 with `br_offset`=0x10. BEQ after the same CMP -> `br_taken`=0.
- AND after CMP -> flags unchanged.
- Opcode 0101 -> `done`=1 and `illegal`=1 in N+2, with no `rf_we`.
- Back-to-back instructions with `instr_valid` held high -> one acceptance every 4 cycles for ALU ops.
- Reset asserted during EXEC -> no `rf_we`, flags 0, `instr_ready`=1 on the next cycle.

Source files
------------

// File: rtl/kurm_pkg.sv
// Shared opcode, ALU encoding, FSM state and decode bundle definitions
// for the KURM ALU sequencer.
package kurm_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_ADC = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_CMP = 4'b1000;
   localparam logic [3:0] OP_BEQ = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;
   localparam logic [3:0] OP_BGT = 4'b1011;
   localparam logic [3:0] OP_NOP = 4'b1111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_ORR = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_BRANCH
   } state_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       use_carry;
      logic       writes_rd;
      logic       sets_c;
      logic       sets_cmp;
      logic       is_branch;
      logic       is_illegal;
   } dec_t;

endpackage

// File: rtl/kurm_decode.sv
// Combinational opcode decoder: maps a KURM opcode to the control bundle
// the sequencer uses to steer the ALU, writeback and flag capture.
module kurm_decode
   import kurm_pkg::*;
(
   input  logic [3:0] i_op,
   output dec_t       o_dec
);

   always_comb begin
      o_dec = '0;
      case (i_op)
         OP_AND: begin
            o_dec.alu_op    = ALU_AND;
            o_dec.writes_rd = 1'b1;
         end
         OP_ORR: begin
            o_dec.alu_op    = ALU_ORR;
            o_dec.writes_rd = 1'b1;
         end
         OP_ADD: begin
            o_dec.alu_op    = ALU_ADD;
            o_dec.writes_rd = 1'b1;
            o_dec.sets_c    = 1'b1;
         end
         OP_ADC: begin
            o_dec.alu_op    = ALU_ADD;
            o_dec.use_carry = 1'b1;
            o_dec.writes_rd = 1'b1;
            o_dec.sets_c    = 1'b1;
         end
         OP_SUB: begin
            o_dec.alu_op    = ALU_SUB;
            o_dec.writes_rd = 1'b1;
            o_dec.sets_c    = 1'b1;
            o_dec.sets_cmp  = 1'b1;
         end
         OP_SLT: begin
            o_dec.alu_op    = ALU_SLT;
            o_dec.writes_rd = 1'b1;
            o_dec.sets_cmp  = 1'b1;
         end
         OP_CMP: begin
            o_dec.alu_op    = ALU_SUB;
            o_dec.sets_c    = 1'b1;
            o_dec.sets_cmp  = 1'b1;
         end
         OP_BEQ, OP_BLT, OP_BGT: begin
            o_dec.is_branch = 1'b1;
         end
         OP_NOP: begin
            o_dec.alu_op = ALU_AND;
         end
         default: begin
            o_dec.is_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/kurm_alu_sequencer.sv
// Multi-cycle control sequencer for the KURM ALU: fetch handshake,
// decode, ALU/register-file steering, flag capture and branch resolution.
module kurm_alu_sequencer
   import kurm_pkg::*;
#(
   parameter int REG_AW   = 4,
   parameter int BR_OFF_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         instr,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic                alu_lt,
   input  logic                alu_eq,
   input  logic                alu_gt,
   input  logic                alu_c_out,
   output logic [2:0]          alu_op,
   output logic                alu_c_in,
   output logic [REG_AW-1:0]   rf_ra,
   output logic [REG_AW-1:0]   rf_rb,
   output logic [REG_AW-1:0]   rf_wa,
   output logic                rf_we,
   output logic                br_taken,
   output logic [BR_OFF_W-1:0] br_offset,
   output logic                flag_lt,
   output logic                flag_eq,
   output logic                flag_gt,
   output logic                flag_c,
   output logic                done,
   output logic                illegal
);

   state_t              r_state;
   logic [3:0]          r_op;
   logic [BR_OFF_W-1:0] r_off;
   logic [2:0]          r_alu_op;
   logic                r_alu_c_in;
   logic [REG_AW-1:0]   r_ra, r_rb, r_wa;
   logic                r_rf_we, r_br_taken, r_done, r_illegal;
   logic [BR_OFF_W-1:0] r_br_offset;
   logic                r_flag_lt, r_flag_eq, r_flag_gt, r_flag_c;
   dec_t                w_dec;
   logic                w_br_cond;
   logic                w_exec;

   kurm_decode u_decode (
      .i_op  (r_op),
      .o_dec (w_dec)
   );

   // NOP has no ALU work; everything that writes or compares goes through EXEC
   assign w_exec = w_dec.writes_rd | w_dec.sets_cmp;

   always_comb begin
      w_br_cond = 1'b0;
      case (r_op)
         OP_BEQ:  w_br_cond = r_flag_eq;
         OP_BLT:  w_br_cond = r_flag_lt;
         OP_BGT:  w_br_cond = r_flag_gt;
         default: w_br_cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_off       <= '0;
         r_alu_op    <= '0;
         r_alu_c_in  <= 1'b0;
         r_ra        <= '0;
         r_rb        <= '0;
         r_wa        <= '0;
         r_rf_we     <= 1'b0;
         r_br_taken  <= 1'b0;
         r_br_offset <= '0;
         r_done      <= 1'b0;
         r_illegal   <= 1'b0;
         r_flag_lt   <= 1'b0;
         r_flag_eq   <= 1'b0;
         r_flag_gt   <= 1'b0;
         r_flag_c    <= 1'b0;
      end else begin
         r_rf_we    <= 1'b0;
         r_br_taken <= 1'b0;
         r_done     <= 1'b0;
         r_illegal  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  r_op    <= instr[15:12];
                  r_off   <= instr[BR_OFF_W-1:0];
                  r_wa    <= instr[8 +: REG_AW];
                  r_ra    <= instr[4 +: REG_AW];
                  r_rb    <= instr[0 +: REG_AW];
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (w_dec.is_branch) begin
                  r_done      <= 1'b1;
                  r_br_taken  <= w_br_cond;
                  r_br_offset <= r_off;
                  r_state     <= ST_BRANCH;
               end else if (w_exec) begin
                  r_alu_op   <= w_dec.alu_op;
                  r_alu_c_in <= w_dec.use_carry & r_flag_c;
                  r_state    <= ST_EXEC;
               end else begin
                  r_done    <= 1'b1;
                  r_illegal <= w_dec.is_illegal;
                  r_state   <= ST_WB;
               end
            end
            ST_EXEC: begin
               if (w_dec.sets_c) begin
                  r_flag_c <= alu_c_out;
               end
               if (w_dec.sets_cmp) begin
                  r_flag_lt <= alu_lt;
                  r_flag_eq <= alu_eq;
                  r_flag_gt <= alu_gt;
               end
               r_rf_we <= w_dec.writes_rd;
               r_done  <= 1'b1;
               r_state <= ST_WB;
            end
            ST_WB:     r_state <= ST_IDLE;
            ST_BRANCH: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = (r_state == ST_IDLE);
   assign alu_op      = r_alu_op;
   assign alu_c_in    = r_alu_c_in;
   assign rf_ra       = r_ra;
   assign rf_rb       = r_rb;
   assign rf_wa       = r_wa;
   assign rf_we       = r_rf_we;
   assign br_taken    = r_br_taken;
   assign br_offset   = r_br_offset;
   assign flag_lt     = r_flag_lt;
   assign flag_eq     = r_flag_eq;
   assign flag_gt     = r_flag_gt;
   assign flag_c      = r_flag_c;
   assign done        = r_done;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_kurm_alu_sequencer.sv
// Directed bench for kurm_alu_sequencer with a small ALU and register-file model.
module tb_kurm_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        alu_lt, alu_eq, alu_gt, alu_c_out;
   logic [2:0]  alu_op;
   logic        alu_c_in;
   logic [3:0]  rf_ra, rf_rb, rf_wa;
   logic        rf_we;
   logic        br_taken;
   logic [7:0]  br_offset;
   logic        flag_lt, flag_eq, flag_gt, flag_c;
   logic        done, illegal;

   int checks = 0;
   int errors = 0;

   logic [15:0] rf [16];
   logic        rf_init;
   logic [15:0] a, b, z;
   logic [16:0] sum;

   always #5 clk = ~clk;

   kurm_alu_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_lt      (alu_lt),
      .alu_eq      (alu_eq),
      .alu_gt      (alu_gt),
      .alu_c_out   (alu_c_out),
      .alu_op      (alu_op),
      .alu_c_in    (alu_c_in),
      .rf_ra       (rf_ra),
      .rf_rb       (rf_rb),
      .rf_wa       (rf_wa),
      .rf_we       (rf_we),
      .br_taken    (br_taken),
      .br_offset   (br_offset),
      .flag_lt     (flag_lt),
      .flag_eq     (flag_eq),
      .flag_gt     (flag_gt),
      .flag_c      (flag_c),
      .done        (done),
      .illegal     (illegal)
   );

   always_comb begin
      a = rf[rf_ra];
      b = rf[rf_rb];
      sum = '0;
      z = '0;
      alu_c_out = 1'b0;
      case (alu_op)
         3'b000: z = a & b;
         3'b001: z = a | b;
         3'b010: begin
            sum = {1'b0, a} + {1'b0, b} + {16'd0, alu_c_in};
            z = sum[15:0];
            alu_c_out = sum[16];
         end
         3'b011: begin
            sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
            z = sum[15:0];
            alu_c_out = sum[16];
         end
         3'b111: z = {15'd0, ($signed(a) < $signed(b))};
         default: z = '0;
      endcase
      alu_lt = $signed(a) < $signed(b);
      alu_eq = (a == b);
      alu_gt = $signed(a) > $signed(b);
   end

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
         rf[2] <= 16'h0001;
         rf[3] <= 16'h0002;
         rf[4] <= 16'hAAAA;
         rf[5] <= 16'hAAAA;
         rf[8] <= 16'h0002;
         rf[9] <= 16'h0004;
      end else if (rf_we) begin
         rf[rf_wa] <= z;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for ready (bounded), presents one instruction, returns in DECODE.
   task automatic issue(input logic [15:0] w);
      int n;
      n = 0;
      while (!instr_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!instr_ready) begin
         errors++;
         $display("FAIL issue_ready timeout for %h", w);
      end
      instr = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr = 16'h0000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rf_init = 1'b1;
      instr_valid = 1'b1;
      instr = 16'h2123;
      tick();
      tick();
      instr_valid = 1'b0;
      reset = 1'b0;
      rf_init = 1'b0;
      checks++;
      if (instr_ready !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got rdy=%b done=%b we=%b exp 1 0 0",
                  instr_ready, done, rf_we);
      end
      checks++;
      if (alu_op !== 3'b000 || br_offset !== 8'h00 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got op=%b off=%h ill=%b exp 000 00 0",
                  alu_op, br_offset, illegal);
      end
      checks++;
      if ({flag_lt, flag_eq, flag_gt, flag_c} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000",
                  {flag_lt, flag_eq, flag_gt, flag_c});
      end
   endtask

   task automatic test_add();
      issue(16'h2123);
      checks++;
      if (instr_ready !== 1'b0 || rf_wa !== 4'd1 || rf_ra !== 4'd2 ||
          rf_rb !== 4'd3) begin
         errors++;
         $display("FAIL add_decode got rdy=%b wa=%0d ra=%0d rb=%0d exp 0 1 2 3",
                  instr_ready, rf_wa, rf_ra, rf_rb);
      end
      tick();
      checks++;
      if (alu_op !== 3'b010 || alu_c_in !== 1'b0 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL add_exec got op=%b cin=%b we=%b exp 010 0 0",
                  alu_op, alu_c_in, rf_we);
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || done !== 1'b1 || rf_wa !== 4'd1 ||
          flag_c !== 1'b0) begin
         errors++;
         $display("FAIL add_wb got we=%b done=%b wa=%0d c=%b exp 1 1 1 0",
                  rf_we, done, rf_wa, flag_c);
      end
      tick();
      checks++;
      if (instr_ready !== 1'b1 || done !== 1'b0 || rf[1] !== 16'h0003) begin
         errors++;
         $display("FAIL add_after got rdy=%b done=%b r1=%h exp 1 0 0003",
                  instr_ready, done, rf[1]);
      end
   endtask

   task automatic test_adc();
      issue(16'h2645);
      tick();
      tick();
      tick();
      checks++;
      if (flag_c !== 1'b1 || rf[6] !== 16'h5554) begin
         errors++;
         $display("FAIL add_carry got c=%b r6=%h exp 1 5554", flag_c, rf[6]);
      end
      issue(16'h4745);
      tick();
      checks++;
      if (alu_op !== 3'b010 || alu_c_in !== 1'b1) begin
         errors++;
         $display("FAIL adc_exec got op=%b cin=%b exp 010 1", alu_op, alu_c_in);
      end
      tick();
      tick();
      checks++;
      if (rf[7] !== 16'h5555 || flag_c !== 1'b1) begin
         errors++;
         $display("FAIL adc_result got r7=%h c=%b exp 5555 1", rf[7], flag_c);
      end
   endtask

   task automatic test_cmp_branch();
      issue(16'h8089);
      tick();
      tick();
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL cmp_wb got we=%b done=%b exp 0 1", rf_we, done);
      end
      tick();
      checks++;
      if ({flag_lt, flag_eq, flag_gt, flag_c} !== 4'b1000) begin
         errors++;
         $display("FAIL cmp_flags got %b exp 1000",
                  {flag_lt, flag_eq, flag_gt, flag_c});
      end
      issue(16'hA010);
      tick();
      checks++;
      if (done !== 1'b1 || br_taken !== 1'b1 || br_offset !== 8'h10) begin
         errors++;
         $display("FAIL blt got done=%b tk=%b off=%h exp 1 1 10",
                  done, br_taken, br_offset);
      end
      tick();
      checks++;
      if (instr_ready !== 1'b1 || br_taken !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL blt_after got rdy=%b tk=%b done=%b exp 1 0 0",
                  instr_ready, br_taken, done);
      end
      issue(16'h9020);
      tick();
      checks++;
      if (done !== 1'b1 || br_taken !== 1'b0 || br_offset !== 8'h20) begin
         errors++;
         $display("FAIL beq got done=%b tk=%b off=%h exp 1 0 20",
                  done, br_taken, br_offset);
      end
      tick();
      checks++;
      if ({flag_lt, flag_eq, flag_gt, flag_c} !== 4'b1000) begin
         errors++;
         $display("FAIL branch_flags got %b exp 1000",
                  {flag_lt, flag_eq, flag_gt, flag_c});
      end
   endtask

   task automatic test_and_flags();
      issue(16'h0A89);
      tick();
      tick();
      tick();
      checks++;
      if ({flag_lt, flag_eq, flag_gt, flag_c} !== 4'b1000 ||
          rf[10] !== 16'h0000) begin
         errors++;
         $display("FAIL and_flags got %b r10=%h exp 1000 0000",
                  {flag_lt, flag_eq, flag_gt, flag_c}, rf[10]);
      end
   endtask

   task automatic test_illegal();
      issue(16'h5000);
      tick();
      checks++;
      if (done !== 1'b1 || illegal !== 1'b1 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL illegal_wb got done=%b ill=%b we=%b exp 1 1 0",
                  done, illegal, rf_we);
      end
      tick();
      checks++;
      if (instr_ready !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_after got rdy=%b ill=%b exp 1 0",
                  instr_ready, illegal);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      int wes;
      acc = 0;
      wes = 0;
      instr = 16'h2B23;
      instr_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (instr_ready) acc++;
         if (rf_we) wes++;
         tick();
      end
      instr_valid = 1'b0;
      checks++;
      if (acc !== 3 || wes !== 3) begin
         errors++;
         $display("FAIL back_to_back got acc=%0d we=%0d exp 3 3", acc, wes);
      end
      checks++;
      if (instr_ready !== 1'b1 || rf[11] !== 16'h0003) begin
         errors++;
         $display("FAIL b2b_after got rdy=%b r11=%h exp 1 0003",
                  instr_ready, rf[11]);
      end
   endtask

   task automatic test_reset_exec();
      issue(16'h3C98);
      tick();
      checks++;
      if (alu_op !== 3'b011) begin
         errors++;
         $display("FAIL rst_exec_op got %b exp 011", alu_op);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 ||
          {flag_lt, flag_eq, flag_gt, flag_c} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_exec got we=%b done=%b rdy=%b fl=%b exp 0 0 1 0000",
                  rf_we, done, instr_ready, {flag_lt, flag_eq, flag_gt, flag_c});
      end
      tick();
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || rf[12] !== 16'h0000) begin
         errors++;
         $display("FAIL rst_exec_after got we=%b done=%b r12=%h exp 0 0 0000",
                  rf_we, done, rf[12]);
      end
   endtask

   initial begin
      reset = 1'b1;
      rf_init = 1'b1;
      instr = 16'h0000;
      instr_valid = 1'b0;
      test_reset();
      test_add();
      test_adc();
      test_cmp_branch();
      test_and_flags();
      test_illegal();
      test_back_to_back();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
